// File: rtl/debug_unit_ctrl_pkg.sv
// debug_unit_pkg: shared constants and types for the debug-unit controller.
//   CMD_*     host command bytes accepted in IDLE (and 'H' during RUN)
//   END_WORD  instruction word that terminates a program load
//   du_state_t controller state encoding
//   sat_inc   saturating 32-bit increment used by the cycle counter
package debug_unit_pkg;

    localparam logic [7:0]  CMD_LOAD = 8'h4C;
    localparam logic [7:0]  CMD_RUN  = 8'h52;
    localparam logic [7:0]  CMD_STEP = 8'h53;
    localparam logic [7:0]  CMD_HALT = 8'h48;
    localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_BYTE,
        LOAD_WRITE,
        RUN,
        STEP,
        REPORT
    } du_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/debug_unit_ctrl_if.sv
// debug_unit_ctrl_if: host byte link, pipeline debug port and status lines.
//   master modport: the controller (drives o_*, samples i_*)
//   slave modport : UART / pipeline / host side
// Signals: i_rx_data/i_rx_valid (RX byte strobe), o_tx_data/o_tx_valid/
// i_tx_ready (TX handshake), i_halt, o_du_data/o_du_addr_wr/o_du_write_en/
// o_du_read_en (IMEM debug port), o_pipe_en, o_busy, o_load_err.
interface debug_unit_ctrl_if;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        i_halt;
    logic [31:0] o_du_data;
    logic [31:0] o_du_addr_wr;
    logic        o_du_write_en;
    logic        o_du_read_en;
    logic        o_pipe_en;
    logic        o_busy;
    logic        o_load_err;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_halt,
        output o_tx_data, o_tx_valid, o_du_data, o_du_addr_wr,
               o_du_write_en, o_du_read_en, o_pipe_en, o_busy, o_load_err
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready, i_halt,
        input  o_tx_data, o_tx_valid, o_du_data, o_du_addr_wr,
               o_du_write_en, o_du_read_en, o_pipe_en, o_busy, o_load_err
    );
endinterface

// File: rtl/debug_unit_ctrl_word_tx.sv
// du_word_tx: sends a 32-bit word as 4 bytes, LSB first, over valid/ready.
//   clk, rst_n       clock, async active-low reset
//   load, word       one-cycle strobe capturing the word to send
//   tx_data/tx_valid byte out; data held while valid && !tx_ready
//   tx_ready         sink accepts byte when tx_valid && tx_ready
//   done             one-cycle pulse after the 4th byte is accepted
module du_word_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);
    logic [31:0] shreg;
    logic [1:0]  idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                shreg    <= word;
                idx      <= '0;
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                if (idx == 2'd3) begin
                    tx_valid <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    shreg <= {8'h00, shreg[31:8]};
                    idx   <= idx + 2'd1;
                end
            end
        end
    end

    assign tx_data = shreg[7:0];
endmodule

// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: sequences the MIPS pipeline from a host byte link.
//   i_clk, i_reset : clock, async active-low reset
//   bus            : debug_unit_ctrl_if.master (RX/TX bytes, halt, IMEM
//                    debug write port, pipe enable, busy, load error)
// Parameters: IMEM_DEPTH (words), MAX_RUN_CYCLES (RUN watchdog limit).
// Optional: define DEBUG_UNIT_WATCHDOG_EN to bound RUN at MAX_RUN_CYCLES
// and flag the timeout in bit 7 of the last report byte.
//
// state      | meaning
// IDLE       | wait for 'L', 'R' or 'S'
// LOAD_BYTE  | collect 4 little-endian bytes of an instruction word
// LOAD_WRITE | one-cycle IMEM write strobe, advance address
// RUN        | pipeline enabled until halt, 'H' (or watchdog)
// STEP       | pipeline enabled for exactly one cycle
// REPORT     | send cycle count to host, LSB first
module debug_unit_ctrl
    import debug_unit_pkg::*;
#(
    parameter int          IMEM_DEPTH     = 256,
    parameter logic [31:0] MAX_RUN_CYCLES = 32'd1_000_000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    debug_unit_ctrl_if.master bus
);
    localparam int            AW       = $clog2(IMEM_DEPTH) + 2;
    localparam logic [AW:0]   ADDR_END = (AW+1)'(IMEM_DEPTH * 4);

    du_state_t   state;
    logic [1:0]  byte_cnt;
    logic [23:0] word_lo;
    logic [AW-1:0] addr;
    logic [AW:0] addr_next;
    logic [31:0] du_data;
    logic [31:0] cyc_cnt;
    logic [31:0] rpt_word;
    logic        write_en;
    logic        load_err;
    logic        tx_load;
    logic        tx_done;
    logic        wd_hit;
    logic        is_halt_byte;

    assign addr_next    = {1'b0, addr} + (AW+1)'(4);
    assign is_halt_byte = bus.i_rx_valid && (bus.i_rx_data == CMD_HALT);

`ifdef DEBUG_UNIT_WATCHDOG_EN
    logic timeout;
    assign wd_hit   = (cyc_cnt >= MAX_RUN_CYCLES);
    assign rpt_word = {cyc_cnt[31] | timeout, cyc_cnt[30:0]};
`else
    logic unused_max_run;
    assign unused_max_run = ^MAX_RUN_CYCLES;
    assign wd_hit   = 1'b0;
    assign rpt_word = cyc_cnt;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
            word_lo  <= '0;
            addr     <= '0;
            du_data  <= '0;
            cyc_cnt  <= '0;
            write_en <= 1'b0;
            load_err <= 1'b0;
            tx_load  <= 1'b0;
`ifdef DEBUG_UNIT_WATCHDOG_EN
            timeout  <= 1'b0;
`endif
        end else begin
            write_en <= 1'b0;
            tx_load  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_rx_valid) begin
                        case (bus.i_rx_data)
                            CMD_LOAD: begin
                                state    <= LOAD_BYTE;
                                addr     <= '0;
                                byte_cnt <= '0;
                                load_err <= 1'b0;
                            end
                            CMD_RUN, CMD_STEP: begin
                                state   <= (bus.i_rx_data == CMD_RUN) ? RUN : STEP;
                                cyc_cnt <= '0;
`ifdef DEBUG_UNIT_WATCHDOG_EN
                                timeout <= 1'b0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                LOAD_BYTE: begin
                    if (bus.i_rx_valid) begin
                        case (byte_cnt)
                            2'd0: word_lo[7:0]   <= bus.i_rx_data;
                            2'd1: word_lo[15:8]  <= bus.i_rx_data;
                            2'd2: word_lo[23:16] <= bus.i_rx_data;
                            default: begin
                                du_data  <= {bus.i_rx_data, word_lo};
                                write_en <= 1'b1;
                                state    <= LOAD_WRITE;
                            end
                        endcase
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                LOAD_WRITE: begin
                    addr <= addr_next[AW-1:0];
                    if (du_data == END_WORD) begin
                        state <= IDLE;
                    end else if (addr_next == ADDR_END) begin
                        load_err <= 1'b1;
                        addr     <= '0;
                        state    <= IDLE;
                    end else begin
                        state <= LOAD_BYTE;
                        // A byte landing on the write cycle starts the next word.
                        if (bus.i_rx_valid) begin
                            word_lo[7:0] <= bus.i_rx_data;
                            byte_cnt     <= 2'd1;
                        end
                    end
                end
                RUN: begin
                    // Halt wins over a simultaneous 'H': no enabled cycle, one report.
                    if (bus.i_halt || wd_hit) begin
                        state   <= REPORT;
                        tx_load <= 1'b1;
`ifdef DEBUG_UNIT_WATCHDOG_EN
                        if (!bus.i_halt) timeout <= 1'b1;
`endif
                    end else begin
                        cyc_cnt <= sat_inc(cyc_cnt);
                        if (is_halt_byte) begin
                            state   <= REPORT;
                            tx_load <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    cyc_cnt <= 32'd1;
                    state   <= REPORT;
                    tx_load <= 1'b1;
                end
                REPORT: begin
                    if (tx_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // tx_load is registered, so the serializer captures the final count.
    du_word_tx u_word_tx (
        .clk      (i_clk),
        .rst_n    (i_reset),
        .load     (tx_load),
        .word     (rpt_word),
        .tx_data  (bus.o_tx_data),
        .tx_valid (bus.o_tx_valid),
        .tx_ready (bus.i_tx_ready),
        .done     (tx_done)
    );

    assign bus.o_du_data     = du_data;
    assign bus.o_du_addr_wr  = {{(32-AW){1'b0}}, addr};
    assign bus.o_du_write_en = write_en;
    assign bus.o_du_read_en  = (state != LOAD_BYTE) && (state != LOAD_WRITE);
    assign bus.o_pipe_en     = ((state == RUN) && !bus.i_halt && !wd_hit) || (state == STEP);
    assign bus.o_busy        = (state != IDLE);
    assign bus.o_load_err    = load_err;
endmodule

// File: tb/tb_debug_unit_ctrl.sv
module tb_debug_unit_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    debug_unit_ctrl_if du();
    debug_unit_ctrl_if du_s();

    debug_unit_ctrl dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (du)
    );

    debug_unit_ctrl #(.IMEM_DEPTH(4), .MAX_RUN_CYCLES(32'd20)) dut_s (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (du_s)
    );

    // Event logs, written only by the negedge monitors.
    int          pipe_total = 0, s_pipe_total = 0;
    int          rd_low_total = 0;
    int          tx_total = 0, s_tx_total = 0;
    int          wr_total = 0, s_wr_total = 0;
    logic [7:0]  tx_log   [0:127];
    logic [7:0]  s_tx_log [0:127];
    logic [31:0] wr_addr  [0:15];
    logic [31:0] wr_data  [0:15];
    logic [31:0] s_wr_addr[0:15];
    logic [31:0] s_wr_data[0:15];
    int          tx_rd = 0, s_tx_rd = 0;

    always @(negedge clk) begin
        if (du.o_pipe_en) pipe_total++;
        if (!du.o_du_read_en) rd_low_total++;
        if (du.o_tx_valid && du.i_tx_ready) begin
            tx_log[tx_total % 128] = du.o_tx_data;
            tx_total++;
        end
        if (du.o_du_write_en) begin
            wr_addr[wr_total % 16] = du.o_du_addr_wr;
            wr_data[wr_total % 16] = du.o_du_data;
            wr_total++;
        end
        if (du_s.o_pipe_en) s_pipe_total++;
        if (du_s.o_tx_valid && du_s.i_tx_ready) begin
            s_tx_log[s_tx_total % 128] = du_s.o_tx_data;
            s_tx_total++;
        end
        if (du_s.o_du_write_en) begin
            s_wr_addr[s_wr_total % 16] = du_s.o_du_addr_wr;
            s_wr_data[s_wr_total % 16] = du_s.o_du_data;
            s_wr_total++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input int s, input logic v, input logic [7:0] b);
        if (s == 0) begin
            du.i_rx_valid = v;
            du.i_rx_data  = b;
        end else begin
            du_s.i_rx_valid = v;
            du_s.i_rx_data  = b;
        end
    endtask

    task automatic send_byte(input int s, input logic [7:0] b);
        drive_rx(s, 1'b1, b);
        step();
        drive_rx(s, 1'b0, 8'h00);
    endtask

    task automatic get_report(input int s, output logic [31:0] w);
        int n = 0;
        int avail;
        avail = (s == 0) ? tx_total - tx_rd : s_tx_total - s_tx_rd;
        while (avail < 4 && n < 2000) begin
            step();
            n++;
            avail = (s == 0) ? tx_total - tx_rd : s_tx_total - s_tx_rd;
        end
        if (avail < 4) begin
            checks++;
            errors++;
            $display("FAIL report_bytes: got %0d bytes expected 4", avail);
            w = 32'hDEAD_DEAD;
        end else if (s == 0) begin
            w = {tx_log[(tx_rd+3)%128], tx_log[(tx_rd+2)%128],
                 tx_log[(tx_rd+1)%128], tx_log[tx_rd%128]};
            tx_rd += 4;
        end else begin
            w = {s_tx_log[(s_tx_rd+3)%128], s_tx_log[(s_tx_rd+2)%128],
                 s_tx_log[(s_tx_rd+1)%128], s_tx_log[s_tx_rd%128]};
            s_tx_rd += 4;
        end
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic        pre_halt;
        int          n;
        logic        stop_halt;
        logic        stop_h;
        logic        exp_report;
        int          exp_pipe;
        logic [31:0] exp_word;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] w;
        int p0, t0, n;

        du.i_rx_data = 8'h00;   du.i_rx_valid = 1'b0;
        du.i_tx_ready = 1'b1;   du.i_halt = 1'b0;
        du_s.i_rx_data = 8'h00; du_s.i_rx_valid = 1'b0;
        du_s.i_tx_ready = 1'b1; du_s.i_halt = 1'b0;

        //          cmd    pre  n    stop_h stop_H rep  pipe word
        vec[0] = '{8'h00, 1'b0, 0,   1'b0, 1'b0, 1'b0, 0,   32'h0};
        vec[1] = '{8'h48, 1'b0, 0,   1'b0, 1'b0, 1'b0, 0,   32'h0};
        vec[2] = '{8'h52, 1'b0, 10,  1'b1, 1'b0, 1'b1, 10,  32'h0000_000A};
        vec[3] = '{8'h53, 1'b0, 0,   1'b0, 1'b0, 1'b1, 1,   32'h0000_0001};
        vec[4] = '{8'h52, 1'b1, 0,   1'b1, 1'b0, 1'b1, 0,   32'h0000_0000};
        vec[5] = '{8'h53, 1'b1, 0,   1'b0, 1'b0, 1'b1, 1,   32'h0000_0001};
        vec[6] = '{8'h52, 1'b0, 3,   1'b0, 1'b1, 1'b1, 4,   32'h0000_0004};
        vec[7] = '{8'h52, 1'b0, 7,   1'b1, 1'b1, 1'b1, 7,   32'h0000_0007};
        vec[8] = '{8'h52, 1'b0, 300, 1'b1, 1'b0, 1'b1, 300, 32'h0000_012C};

        // Reset state
        repeat (3) step();
        check("rst_busy",     {31'b0, du.o_busy},      32'd0);
        check("rst_read_en",  {31'b0, du.o_du_read_en}, 32'd1);
        check("rst_pipe_en",  {31'b0, du.o_pipe_en},   32'd0);
        check("rst_tx_valid", {31'b0, du.o_tx_valid},  32'd0);
        check("rst_write_en", {31'b0, du.o_du_write_en}, 32'd0);
        check("rst_load_err", {31'b0, du.o_load_err},  32'd0);
        check("rst_addr",     du.o_du_addr_wr,         32'd0);
        check("rst_data",     du.o_du_data,            32'd0);
        rst_n = 1'b1;
        step();

        // Two-word load, back-to-back bytes (one lands on the write cycle)
        t0 = rd_low_total;
        send_byte(0, 8'h4C);
        send_byte(0, 8'h13); send_byte(0, 8'h00);
        send_byte(0, 8'h22); send_byte(0, 8'h20);
        send_byte(0, 8'hFF); send_byte(0, 8'hFF);
        send_byte(0, 8'hFF); send_byte(0, 8'hFF);
        repeat (3) step();
        check("load_writes", wr_total, 2);
        check("load_addr0",  wr_addr[0], 32'h0);
        check("load_data0",  wr_data[0], 32'h2022_0013);
        check("load_addr1",  wr_addr[1], 32'h4);
        check("load_data1",  wr_data[1], 32'hFFFF_FFFF);
        check("load_rd_low", rd_low_total - t0, 9);
        check("load_idle",   {31'b0, du.o_busy}, 32'd0);
        check("load_rd_en",  {31'b0, du.o_du_read_en}, 32'd1);
        check("load_no_err", {31'b0, du.o_load_err}, 32'd0);

        // Overflow on a 4-word IMEM
        send_byte(1, 8'h4C);
        for (int k = 1; k <= 4; k++) begin
            send_byte(1, 8'(k)); send_byte(1, 8'h00);
            send_byte(1, 8'h00); send_byte(1, 8'h00);
        end
        repeat (3) step();
        check("ovf_writes", s_wr_total, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_addr%0d", k), s_wr_addr[k], 32'(4*k));
            check($sformatf("ovf_data%0d", k), s_wr_data[k], 32'(k+1));
        end
        check("ovf_err",  {31'b0, du_s.o_load_err}, 32'd1);
        check("ovf_idle", {31'b0, du_s.o_busy},     32'd0);
        check("ovf_addr", du_s.o_du_addr_wr,        32'd0);
        send_byte(1, 8'h4C);
        check("ovf_err_clr", {31'b0, du_s.o_load_err}, 32'd0);
        send_byte(1, 8'hFF); send_byte(1, 8'hFF);
        send_byte(1, 8'hFF); send_byte(1, 8'hFF);
        repeat (3) step();
        check("ovf_term_idle", {31'b0, du_s.o_busy}, 32'd0);
        check("ovf_term_err",  {31'b0, du_s.o_load_err}, 32'd0);

        // Command table: run/step/ignored bytes
        for (int i = 0; i < NV; i++) begin
            p0 = pipe_total;
            t0 = tx_total;
            du.i_halt = vec[i].pre_halt;
            send_byte(0, vec[i].cmd);
            repeat (vec[i].n) step();
            if (vec[i].stop_halt || vec[i].stop_h) begin
                if (vec[i].stop_halt) du.i_halt = 1'b1;
                if (vec[i].stop_h) drive_rx(0, 1'b1, 8'h48);
                step();
                drive_rx(0, 1'b0, 8'h00);
                du.i_halt = 1'b0;
            end
            if (vec[i].exp_report) begin
                get_report(0, w);
                check($sformatf("vec%0d_word", i), w, vec[i].exp_word);
            end else begin
                repeat (5) step();
                check($sformatf("vec%0d_no_tx", i), tx_total - t0, 0);
            end
            repeat (3) step();
            du.i_halt = 1'b0;
            check($sformatf("vec%0d_pipe", i), pipe_total - p0, vec[i].exp_pipe);
            check($sformatf("vec%0d_idle", i), {31'b0, du.o_busy}, 32'd0);
        end

        // STEP with TX stalled: data must hold
        p0 = pipe_total;
        du.i_tx_ready = 1'b0;
        send_byte(0, 8'h53);
        n = 0;
        while (!du.o_tx_valid && n < 20) begin step(); n++; end
        check("stall_valid", {31'b0, du.o_tx_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_data%0d", k), {24'b0, du.o_tx_data}, 32'h01);
            step();
        end
        du.i_tx_ready = 1'b1;
        get_report(0, w);
        check("stall_word", w, 32'h0000_0001);
        check("stall_pipe", pipe_total - p0, 1);
        repeat (3) step();

        // Reset in the middle of REPORT
        du.i_tx_ready = 1'b0;
        send_byte(0, 8'h52);
        repeat (5) step();
        du.i_halt = 1'b1;
        step();
        du.i_halt = 1'b0;
        n = 0;
        while (!du.o_tx_valid && n < 20) begin step(); n++; end
        check("mid_rpt_valid", {31'b0, du.o_tx_valid}, 32'd1);
        t0 = tx_total;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", {31'b0, du.o_tx_valid}, 32'd0);
        check("mid_rst_busy",     {31'b0, du.o_busy},     32'd0);
        check("mid_rst_read_en",  {31'b0, du.o_du_read_en}, 32'd1);
        step();
        rst_n = 1'b1;
        du.i_tx_ready = 1'b1;
        repeat (10) step();
        check("mid_rst_no_tx", tx_total - t0, 0);
        check("mid_rst_idle",  {31'b0, du.o_busy}, 32'd0);
        tx_rd = tx_total;

`ifdef DEBUG_UNIT_WATCHDOG_EN
        p0 = s_pipe_total;
        s_tx_rd = s_tx_total;
        send_byte(1, 8'h52);
        get_report(1, w);
        check("wd_word", w, 32'h8000_0014);
        check("wd_pipe", s_pipe_total - p0, 20);
        repeat (3) step();
        send_byte(1, 8'h53);
        get_report(1, w);
        check("wd_clear_step", w, 32'h0000_0001);
        repeat (3) step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
